// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the data RAM controller: bus width, zero word,
// FSM state encodings, byte-select encodings and the misalignment rule.
package data_ram_ctrl_pkg;

  localparam int REG_BUS_W = 32;
  localparam int LANES     = REG_BUS_W / 8;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

  localparam logic [LANES-1:0] SEL_NONE    = 4'b0000;
  localparam logic [LANES-1:0] SEL_BYTE0   = 4'b0001;
  localparam logic [LANES-1:0] SEL_HALF_LO = 4'b0011;
  localparam logic [LANES-1:0] SEL_HALF_HI = 4'b1100;
  localparam logic [LANES-1:0] SEL_WORD    = 4'b1111;

  // Word access must sit on a 4-byte boundary, half-word access on a 2-byte boundary.
  function automatic logic is_misaligned(input logic [LANES-1:0] sel, input logic [1:0] addr_lo);
    return ((sel == SEL_WORD) && (addr_lo != 2'b00)) ||
           (((sel == SEL_HALF_LO) || (sel == SEL_HALF_HI)) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/data_ram_ctrl_array.sv
// Single-port word storage with per-byte write enables, synchronous write
// and asynchronous read. Contents are deliberately not reset.
module data_ram_array
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    idx_i,
  input  logic [LANES-1:0]     be_i,
  input  logic [REG_BUS_W-1:0] wdata_i,
  output logic [REG_BUS_W-1:0] rdata_o
);

  logic [REG_BUS_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < LANES; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM access sequencer for the MEM stage: accepts one request, waits
// WAIT_CYCLES, pulses ack. Optional misalignment check: DATA_RAM_MISALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | ready; a request is latched on the next edge
// WAIT    | counting down the configured wait cycles
// ACK     | one-cycle completion; read data valid on data_o
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [3:0]           sel_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic                 ack_o,
`ifdef DATA_RAM_MISALIGN_CHECK_EN
  output logic                 misalign_o,
`endif
  output logic                 stallreq_o
);

`ifdef DATA_RAM_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [LANES-1:0]       sel_q, sel_d;
  logic [REG_BUS_W-1:0]   wdata_q, wdata_d;
  logic                   mis_q, mis_d;
  logic                   enter_ack;
  logic                   ram_we;
  logic [REG_BUS_W-1:0]   ram_rdata;
  logic                   unused_addr;

  assign unused_addr = ^addr_i[31:ADDR_W+2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    enter_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[ADDR_W+1:2];
          sel_d   = sel_i;
          wdata_d = data_i;
          mis_d   = MIS_EN && is_misaligned(sel_i, addr_i[1:0]);
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= ZERO_WORD;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  // The _d side already holds the request being committed, which also covers
  // the zero-wait case where acceptance and commit share one edge.
  assign ram_we = enter_ack & we_d & ~mis_d & ~rst;

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (idx_d),
    .be_i    (sel_d),
    .wdata_i (wdata_d),
    .rdata_o (ram_rdata)
  );

  assign ack_o      = (state_q == ST_ACK);
  assign data_o     = (ack_o && !we_q && !mis_q) ? ram_rdata : ZERO_WORD;
  assign stallreq_o = req_i & (state_q != ST_ACK);

`ifdef DATA_RAM_MISALIGN_CHECK_EN
  assign misalign_o = ack_o & mis_q;
`endif

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed vector table, randomized
// transactions against a word-array model, reset abort and zero-wait streaming.
module tb_data_ram_ctrl;

  localparam int WAIT_A = 2;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2**ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_req = 0, a_we = 0;
  logic [31:0] a_addr = 0, a_data = 0;
  logic [3:0]  a_sel = 0;
  logic [31:0] a_dout;
  logic        a_ack, a_stall;

  logic        b_req = 0, b_we = 0;
  logic [31:0] b_addr = 0, b_data = 0;
  logic [3:0]  b_sel = 0;
  logic [31:0] b_dout;
  logic        b_ack, b_stall;

`ifdef DATA_RAM_MISALIGN_CHECK_EN
  logic a_mis, b_mis;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_ram_ctrl #(.WAIT_CYCLES(WAIT_A), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .sel_i(a_sel), .data_i(a_data), .data_o(a_dout), .ack_o(a_ack),
`ifdef DATA_RAM_MISALIGN_CHECK_EN
    .misalign_o(a_mis),
`endif
    .stallreq_o(a_stall)
  );

  data_ram_ctrl #(.WAIT_CYCLES(0), .ADDR_W(ADDR_W)) dut0 (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .sel_i(b_sel), .data_i(b_data), .data_o(b_dout), .ack_o(b_ack),
`ifdef DATA_RAM_MISALIGN_CHECK_EN
    .misalign_o(b_mis),
`endif
    .stallreq_o(b_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_mis(input logic [3:0] sel, input logic [31:0] addr);
`ifdef DATA_RAM_MISALIGN_CHECK_EN
    return (sel == 4'b1111 && addr[1:0] != 2'b00) ||
           ((sel == 4'b0011 || sel == 4'b1100) && addr[0]);
`else
    return (sel == 4'hx) && (addr == 32'hx);
`endif
  endfunction

  // One transaction on the WAIT_A instance, checked against ref_mem.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] data, input bit scramble, output logic [31:0] rd);
    logic [31:0] exp_d;
    bit mis, got;
    int idx, cyc;
    mis   = model_mis(sel, addr);
    idx   = int'((addr >> 2) % DEPTH);
    exp_d = (we || mis) ? 32'h0 : ref_mem[idx];
    rd    = 32'h0;
    @(negedge clk);
    a_req = 1; a_we = we; a_addr = addr; a_sel = sel; a_data = data;
    #1 chk("stall_idle", a_stall, 1);
    @(posedge clk);
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (a_ack) got = 1;
      else begin
        chk("data_wait", a_dout, 0);
        chk("stall_wait", a_stall, a_req);
`ifdef DATA_RAM_MISALIGN_CHECK_EN
        chk("mis_wait", a_mis, 0);
`endif
        if (scramble) begin
          a_req = 1'($urandom); a_we = 1'($urandom); a_addr = $urandom;
          a_sel = 4'($urandom); a_data = $urandom;
        end
      end
    end
    chk("ack_seen", got, 1);
    if (got) begin
      chk("ack_latency", 32'(cyc), 32'(WAIT_A + 1));
      chk("data_ack", a_dout, exp_d);
      chk("stall_ack", a_stall, 0);
`ifdef DATA_RAM_MISALIGN_CHECK_EN
      chk("mis_ack", a_mis, mis);
`endif
      rd = a_dout;
    end
    if (we && !mis) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    end
    a_req = 0;
    @(negedge clk);
    chk("ack_pulse_end", a_ack, 0);
    chk("data_after", a_dout, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rd, old;

    vecs[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEAA};
    vecs[4] = '{1'b0, 32'h0000_1010, 4'hF, 32'h0,         32'hDEAD_BEAA};
    vecs[5] = '{1'b1, 32'h0000_0014, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_1014, 4'h0, 32'h1122_3344, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'hCAFE_F00D};
    vecs[8] = '{1'b1, 32'h0000_0014, 4'hA, 32'hAABB_CCDD, 32'h0};
    vecs[9] = '{1'b0, 32'h0000_0014, 4'h3, 32'h0,         32'hAAFE_CC0D};

    repeat (2) @(negedge clk);
    chk("rst_ack", a_ack, 0);
    chk("rst_data", a_dout, 0);
    chk("rst_stall", a_stall, 0);
    rst = 0;

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, 1'b0, rd);
      chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    for (int w = 0; w < 16; w++)
      txn(1'b1, 32'(w * 4), 4'hF, $urandom, 1'b0, rd);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      addr = {20'($urandom), 10'($urandom_range(0, 15)), 2'b00};
      txn(1'($urandom), addr, 4'($urandom), $urandom, 1'($urandom), rd);
    end

    // Reset lands one cycle after acceptance, right before the commit edge.
    old = ref_mem[4];
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 32'h10; a_sel = 4'hF; a_data = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    a_req = 0;
    @(posedge clk);
    #1 rst = 1;
    a_req = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_ack", a_ack, 0);
      chk("abort_data", a_dout, 0);
      chk("abort_stall", a_stall, 1);
    end
    a_req = 0;
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_ack", a_ack, 0);
    end
    txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd);
    chk("abort_old_word", rd, old);

    // Zero-wait instance: request held high streams one access per two cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        b_req = 1; b_we = 1; b_addr = 32'h20; b_sel = 4'hF; b_data = 32'h0BAD_CAFE;
      end else begin
        b_we = 0; b_data = $urandom;
      end
      #1;
      chk($sformatf("b2b_ack%0d", i), b_ack, (i % 2));
      chk($sformatf("b2b_stall%0d", i), b_stall, !(i % 2));
      chk($sformatf("b2b_data%0d", i), b_dout, (i % 2 == 1 && i >= 3) ? 32'h0BAD_CAFE : 32'h0);
    end
    b_req = 0;

`ifdef DATA_RAM_MISALIGN_CHECK_EN
    old = ref_mem[4];
    txn(1'b0, 32'h12, 4'hF, 32'h0, 1'b0, rd);
    chk("mis_read_zero", rd, 0);
    txn(1'b1, 32'h12, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    txn(1'b1, 32'h11, 4'h3, 32'hFFFF_FFFF, 1'b0, rd);
    txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd);
    chk("mis_storage", rd, old);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
